uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 434, giving clk cycles per serial bit; legal range 2..8191, held in a 13-bit counter.
REQ-002 SHALL have parameter DATA_BITS, default 8, giving payload bits per frame; legal range 5..8.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port tx_valid, input, 1, meaning a frame request is presented.
REQ-006 SHALL have port tx_ready, output, 1, meaning the block can accept a frame this cycle.
REQ-007 SHALL have port tx_data, input, DATA_BITS, the payload, sent LSB first.
REQ-008 SHALL have port parity_mode, input, 2, where 00 = none, 01 = even, 10 = odd, 11 = none.
REQ-009 SHALL have port stop2, input, 1, where 0 = one stop bit and 1 = two stop bits.
REQ-010 SHALL have port tx_busy, output, 1, high while a frame is in progress.
REQ-011 SHALL have port tx_done, output, 1, a one-cycle pulse at frame completion.
REQ-012 SHALL have port tx_pin, output, 1, the serial line, idle high.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL drive tx_ready = 1 only in IDLE, and accept a frame on the cycle where tx_valid and tx_ready are both 1.
REQ-015 SHALL capture tx_data, parity_mode and stop2 on acceptance; input changes during the frame SHALL have no effect.
REQ-016 SHALL drive tx_pin low from the cycle after acceptance (START), for exactly CLK_PER_BIT cycles.
REQ-017 SHALL hold every bit (start, data, parity, stop) on tx_pin for exactly CLK_PER_BIT cycles, with no glitches at bit boundaries.
REQ-018 SHALL send data bits LSB first, in DATA state, and hold a bit index counting 0..DATA_BITS-1.
REQ-019 SHALL send a parity bit when the mode is even or odd: even = XOR of the captured bits; odd = inverted XOR.
REQ-020 SHALL skip the PARITY state when the mode is none.
REQ-021 SHALL drive tx_pin high in STOP, for CLK_PER_BIT cycles, or 2*CLK_PER_BIT cycles when stop2 was captured as 1.
REQ-022 SHALL give a frame length of CLK_PER_BIT*(1+DATA_BITS+P+S) cycles, where P is 0 or 1 and S is 1 or 2.
REQ-023 SHALL return to IDLE after STOP, pulse tx_done for exactly that first IDLE cycle, and assert tx_ready in that same cycle.
REQ-024 SHALL allow back-to-back frames: a new start bit begins one cycle after the first IDLE cycle, with no extra idle gap.
REQ-025 SHALL drive tx_busy = 1 in every state other than IDLE.
REQ-026 SHALL ignore tx_valid while busy; the request is not queued.
REQ-027 SHALL wrap the bit counter to 0 at CLK_PER_BIT-1, at the point of each bit transition.

Reset
REQ-028 SHALL, with rst_n = 0 at a rising edge, force state IDLE, tx_pin = 1, tx_done = 0, tx_busy = 0, tx_ready = 1, and clear the counters.
REQ-029 SHALL, on reset mid-frame, abort the frame: tx_pin = 1 from the next cycle and no tx_done pulse.
REQ-030 SHALL make reset take priority over a simultaneous tx_valid.

Configuration
REQ-031 SHALL compile in parity generation and the PARITY state only when macro UART_TX_PARITY_EN is defined.
REQ-032 SHALL, when UART_TX_PARITY_EN is undefined, keep the parity_mode port but ignore it, always send no parity, and omit the PARITY state logic.

Verification (CLK_PER_BIT = 4, DATA_BITS = 8; acceptance at cycle 0)
REQ-033 SHALL cover: 0x55, mode 00, stop2 = 0 -> tx_pin bits 0,1,0,1,0,1,0,1,0,1, each 4 cycles, over cycles 1..40; tx_done at cycle 41.
REQ-034 SHALL cover: 0x07, mode 01 (even) -> parity bit 1 over cycles 37..40; stop over cycles 41..44; tx_done at cycle 45.
REQ-035 SHALL cover: 0x07, mode 10 (odd), stop2 = 1 -> parity bit 0; stop over cycles 41..48; tx_done at cycle 49.
REQ-036 SHALL cover: tx_valid held high with 0xA5 then 0x3C -> second start bit at cycle 42; tx_data changed mid-frame has no effect.
REQ-037 SHALL cover: rst_n = 0 at cycle 20 of a frame -> tx_pin = 1 at cycle 21, tx_ready = 1, no tx_done pulse.
REQ-038 SHALL cover: UART_TX_PARITY_EN undefined, mode 01 -> frame identical to REQ-033, tx_done at cycle 41.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter.
//
// Sends one frame per accepted request: start bit (low), DATA_BITS payload
// bits LSB first, an optional parity bit, then one or two stop bits (high).
// Every bit is held on tx_pin for exactly CLK_PER_BIT clock cycles.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> parity generation and the PARITY state are
//                                   built; parity_mode selects none/even/odd.
//                      undefined -> parity_mode is accepted but ignored and
//                                   frames never carry a parity bit.
//
// Parameters:
//   CLK_PER_BIT  clk cycles per serial bit (2..8191)
//   DATA_BITS    payload bits per frame (5..8)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   tx_valid     frame request presented
//   tx_ready     block can accept a frame this cycle (IDLE only)
//   tx_data      payload, sent LSB first
//   parity_mode  00 none, 01 even, 10 odd, 11 none
//   stop2        0 one stop bit, 1 two stop bits
//   tx_busy      frame in progress
//   tx_done      one-cycle pulse on the first IDLE cycle after a frame
//   tx_pin       serial line, idle high
//   dbg_state_o  current FSM state (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
//
// Handshake: a frame is accepted on a rising edge where tx_valid and tx_ready
// are both 1. tx_ready is high only in IDLE; tx_valid seen while busy is
// dropped, never queued. The start bit appears on tx_pin the cycle after
// acceptance, so holding tx_valid high gives back-to-back frames with the
// done/ready cycle as the only gap between stop and the next start bit.

module uart_tx_cfg #(
    parameter int unsigned CLK_PER_BIT = 434,
    parameter int unsigned DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx_pin,
    output logic [2:0]           dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam logic [12:0] CNT_LAST = 13'(CLK_PER_BIT - 1);
    localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

    state_e                 state_q;
    logic [12:0]            cnt_q;
    logic [2:0]             bit_idx_q;
    logic [DATA_BITS-1:0]   data_q;       // shifts right; bit 0 is on the line
    logic                   stop2_q;
    logic                   stop_second_q;
    logic                   tx_pin_q;
    logic                   tx_done_q;
`ifdef UART_TX_PARITY_EN
    logic                   par_en_q;
    logic                   par_bit_q;
`else
    logic                   unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
`endif

    // Last cycle of the current serial bit: every bit transition happens here.
    logic bit_end;
    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            data_q        <= '0;
            stop2_q       <= 1'b0;
            stop_second_q <= 1'b0;
            tx_pin_q      <= 1'b1;
            tx_done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q      <= 1'b0;
            par_bit_q     <= 1'b0;
`endif
        end else begin
            tx_done_q <= 1'b0;
            // Counter wraps at the bit boundary, otherwise counts up while busy.
            if (state_q != IDLE) begin
                cnt_q <= bit_end ? '0 : cnt_q + 13'd1;
            end
            case (state_q)
                IDLE: begin
                    tx_pin_q <= 1'b1;
                    if (tx_valid) begin
                        // Capture everything the frame needs; inputs are
                        // free to change from here on.
                        data_q        <= tx_data;
                        stop2_q       <= stop2;
                        stop_second_q <= 1'b0;
                        bit_idx_q     <= '0;
                        cnt_q         <= '0;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        // Even: XOR of data; odd: inverted XOR.
                        par_bit_q <= (^tx_data) ^ (parity_mode == 2'b10);
`endif
                        tx_pin_q <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_pin_q  <= data_q[0];
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                tx_pin_q <= par_bit_q;
                                state_q  <= PARITY;
                            end else begin
                                tx_pin_q <= 1'b1;
                                state_q  <= STOP;
                            end
`else
                            tx_pin_q <= 1'b1;
                            state_q  <= STOP;
`endif
                        end else begin
                            tx_pin_q  <= data_q[1];
                            data_q    <= data_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx_pin_q <= 1'b1;
                        state_q  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (stop2_q && !stop_second_q) begin
                            // Second stop bit: line stays high, one more bit time.
                            stop_second_q <= 1'b1;
                        end else begin
                            tx_pin_q  <= 1'b1;
                            tx_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_pin_q <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = (state_q == IDLE);
    assign tx_busy     = (state_q != IDLE);
    assign tx_done     = tx_done_q;
    assign tx_pin      = tx_pin_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg with CLK_PER_BIT = 4, DATA_BITS = 8.
// Every cycle the outputs {tx_busy, tx_done, tx_pin, tx_ready} are compared
// at the falling edge against a cycle-by-cycle expectation queue filled by
// the driver when a frame is presented; an empty queue means the block must
// be idle (busy 0, done 0, pin 1, ready 1).

module tb_uart_tx_cfg;

    localparam int CPB = 4;
    localparam int DB  = 8;
    localparam int W   = 4;
    localparam logic [W-1:0] IDLE_E = 4'b0011;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          tx_valid;
    logic          tx_ready;
    logic [DB-1:0] tx_data;
    logic [1:0]    parity_mode;
    logic          stop2;
    logic          tx_busy;
    logic          tx_done;
    logic          tx_pin;
    logic [2:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int           err_cnt = 0;
    int           chk_cnt = 0;
    bit           mon_en  = 1'b0;

    uart_tx_cfg #(
        .CLK_PER_BIT(CPB),
        .DATA_BITS  (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_pin     (tx_pin),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, checks=%0d errors=%0d", chk_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%b expected=%b (busy,done,pin,ready) at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check_eq("frame", {tx_busy, tx_done, tx_pin, tx_ready}, e);
            end else begin
                check_eq("idle", {tx_busy, tx_done, tx_pin, tx_ready}, IDLE_E);
            end
        end
    end

    // Expected per-cycle outputs for a frame accepted at the next rising edge.
    function automatic void push_frame(input logic [DB-1:0] d, input logic [1:0] m, input logic s2);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (PAR_BUILT && (m == 2'b01 || m == 2'b10))
            bits.push_back((m == 2'b01) ? (^d) : ~(^d));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int c = 0; c < CPB; c++) exp_q.push_back({1'b1, 1'b0, bits[k], 1'b0});
        end
        exp_q.push_back(4'b0111);
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a falling edge while the block is idle.
    task automatic wait_drain();
        int budget = 200;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        check_eq("drain", {3'b000, exp_q.size() == 0}, 4'b0001);
        exp_q.delete();
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] m, input logic s2, input bit hold);
        tx_data     = d;
        parity_mode = m;
        stop2       = s2;
        tx_valid    = 1'b1;
        push_frame(d, m, s2);
        @(posedge clk); #1;
        if (!hold) tx_valid = 1'b0;
        // Scramble inputs mid-frame; the captured copy must be used.
        tx_data     = DB'($urandom_range(0, 255));
        parity_mode = 2'($urandom_range(0, 3));
        stop2       = 1'($urandom_range(0, 1));
        wait_drain();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b0;
        tx_valid    = 1'b1;   // reset must win over a request
        tx_data     = 8'hFF;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        repeat (3) @(posedge clk);
        #1 mon_en = 1'b1;
        idle_cycles(2);
        tx_valid = 1'b0;
        rst_n    = 1'b1;
        idle_cycles(3);

        // Plain 8N1 frame, alternating pattern.
        send_frame(8'h55, 2'b00, 1'b0, 1'b0);
        idle_cycles(2);
        // Even parity, one stop bit.
        send_frame(8'h07, 2'b01, 1'b0, 1'b0);
        idle_cycles(1);
        // Odd parity, two stop bits.
        send_frame(8'h07, 2'b10, 1'b1, 1'b0);
        idle_cycles(3);
        // Mode 11 behaves as no parity.
        send_frame(8'hC3, 2'b11, 1'b1, 1'b0);
        idle_cycles(2);

        // Back-to-back: tx_valid held high across the first frame.
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0);
        idle_cycles(2);

        // Random frames, some back-to-back.
        for (int n = 0; n < 8; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            send_frame(DB'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), hold);
            if (!hold) idle_cycles($urandom_range(0, 3));
        end
        tx_valid = 1'b0;
        idle_cycles(2);

        // Reset asserted at cycle 20 of a frame, with a request pending.
        tx_data     = 8'h96;
        parity_mode = 2'b01;
        stop2       = 1'b1;
        tx_valid    = 1'b1;
        push_frame(8'h96, 2'b01, 1'b1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        idle_cycles(20);
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        idle_cycles(12);

        // Block still works after the aborted frame.
        send_frame(8'h81, 2'b10, 1'b0, 1'b0);
        idle_cycles(3);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
